// File: rtl/lsu_pkg.sv
// Shared types and decode constants for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Store size codes (mem_write)
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  // Load type codes (mem_read); 101-111 decode as lw
  localparam logic [2:0] MR_LW  = 3'b000;
  localparam logic [2:0] MR_LB  = 3'b001;
  localparam logic [2:0] MR_LH  = 3'b010;
  localparam logic [2:0] MR_LBU = 3'b011;
  localparam logic [2:0] MR_LHU = 3'b100;

  // A store, when present, decides the access size; otherwise the load type does.
  function automatic logic misaligned_access(logic [1:0] mw, logic [2:0] mr, logic [1:0] lo);
    logic half;
    logic word;
    if (mw != MW_NONE) begin
      half = (mw == MW_SH);
      word = (mw == MW_SW);
    end else begin
      half = (mr == MR_LH) || (mr == MR_LHU);
      word = !((mr == MR_LB) || (mr == MR_LBU) || half);
    end
    return (half && lo[0]) || (word && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus: single outstanding req/ack transaction, rdata valid with ack.
interface lsu_ctrl_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_lo,
  input  logic [1:0]  mem_write,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_lo,
  input  logic [2:0]  mem_read,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: loads read the whole word, so anything but sb/sh enables all lanes
  always_comb begin
    be      = 4'b1111;
    st_data = wdata;
    unique case (mem_write)
      MW_SB: begin
        be      = 4'b0001 << st_lo;
        st_data = {4{wdata[7:0]}};
      end
      MW_SH: begin
        be      = 4'b0011 << {st_lo[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the lane from the low address bits, then extend
  always_comb begin
    ld_byte = rdata[7:0];
    unique case (ld_lo)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ;
    endcase
    ld_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];
    case (mem_read)
      MR_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      MR_LBU:  load_data = {24'h0, ld_byte};
      MR_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      MR_LHU:  load_data = {16'h0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one req/ack bus transaction per access, stalls the
// pipeline until it completes or times out.
// Optional: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses without a bus cycle.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            is_load,
  input  logic [1:0]      mem_write,
  input  logic [2:0]      mem_read,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            bus_err,
  output logic            misaligned,
  lsu_ctrl_if.master      bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      rd_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] load_q;

  logic            access;
  logic            misal;
  logic            timeout_hit;
  logic            capture;
  logic            ld_capture;
  logic            ld_clear;
  logic [3:0]      be_new;
  logic [31:0]     st_data;
  logic [31:0]     ld_ext;

  assign access = mem_valid && (is_load || (mem_write != MW_NONE));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = misaligned_access(mem_write, mem_read, addr[1:0]);
`else
  // Low address bits are simply truncated to natural alignment by the lane logic
  assign misal = 1'b0;
`endif

  // Counter holds the number of REQ cycles already spent, so the last one is CntLast
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  lsu_lane_align u_lane (
    .st_lo     (addr[1:0]),
    .mem_write (mem_write),
    .wdata     (wdata),
    .be        (be_new),
    .st_data   (st_data),
    .ld_lo     (lo_q),
    .mem_read  (rd_q),
    .rdata     (bus.bus_rdata),
    .load_data (ld_ext)
  );

  // Next-state and pipeline-facing outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    stall      = 1'b0;
    done       = 1'b0;
    bus_err    = 1'b0;
    misaligned = 1'b0;
    capture    = 1'b0;
    ld_capture = 1'b0;
    ld_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (misal) begin
            misaligned = 1'b1;
            done       = 1'b1;
          end else begin
            stall   = 1'b1;
            capture = 1'b1;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (bus.bus_ack) begin
          ld_capture = !we_q;
          state_d    = DONE;
        end else if (timeout_hit) begin
          ld_clear = 1'b1;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        bus_err = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and the latched transaction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= MR_LW;
      lo_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        we_q    <= (mem_write != MW_NONE);
        addr_q  <= {addr[XLEN-1:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= st_data;
        rd_q    <= mem_read;
        lo_q    <= addr[1:0];
      end
      if (ld_capture) begin
        load_q <= ld_ext;
      end else if (ld_clear) begin
        load_q <= '0;
      end
    end
  end

  // bus_req derives from state alone so an async reset drops it at once
  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign load_data     = load_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl. A second instance with TIMEOUT_CYCLES=4 covers the abort path.
// Misaligned-trap checks follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        is_load;
  logic [1:0]  mem_write;
  logic [2:0]  mem_read;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        stall, done, bus_err, misaligned;
  logic [31:0] load_data;
  logic        stall_to, done_to, bus_err_to, misaligned_to;
  logic [31:0] load_data_to;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl_if bus_if ();
  lsu_ctrl_if bus_if_to ();

  lsu_ctrl #(.TIMEOUT_CYCLES(16), .XLEN(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .is_load    (is_load),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .bus_err    (bus_err),
    .misaligned (misaligned),
    .bus        (bus_if)
  );

  lsu_ctrl #(.TIMEOUT_CYCLES(4), .XLEN(32)) u_dut_to (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .is_load    (is_load),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall_to),
    .done       (done_to),
    .load_data  (load_data_to),
    .bus_err    (bus_err_to),
    .misaligned (misaligned_to),
    .bus        (bus_if_to)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xact(input string tag, input logic ld, input logic [1:0] mw,
                          input logic [2:0] mr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at, input logic exp_we,
                          input logic [3:0] exp_be, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    step();
    mem_valid = 1'b1; is_load = ld; mem_write = mw; mem_read = mr; addr = a; wdata = wd;
    #1;
    check_eq({tag, ".accept_stall"}, 32'(stall), 32'd1);
    check_eq({tag, ".accept_req"}, 32'(bus_if.bus_req), 32'd0);
    check_eq({tag, ".accept_misal"}, 32'(misaligned), 32'd0);
    for (int i = 1; i <= ack_at; i++) begin
      step();
      if (i == ack_at) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = rd;
      end
      #1;
      check_eq({tag, ".req"}, 32'(bus_if.bus_req), 32'd1);
      check_eq({tag, ".stall"}, 32'(stall), 32'd1);
      check_eq({tag, ".we"}, 32'(bus_if.bus_we), 32'(exp_we));
      check_eq({tag, ".be"}, 32'(bus_if.bus_be), 32'(exp_be));
      check_eq({tag, ".addr"}, bus_if.bus_addr, exp_addr);
      check_eq({tag, ".wdata"}, bus_if.bus_wdata, exp_wdata);
    end
    step();
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;
    #1;
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".done_stall"}, 32'(stall), 32'd0);
    check_eq({tag, ".done_req"}, 32'(bus_if.bus_req), 32'd0);
    check_eq({tag, ".done_err"}, 32'(bus_err), 32'd0);
    check_eq({tag, ".load_data"}, load_data, exp_load);
    // mem_valid is still high in DONE; it must not start a second access
    step();
    mem_valid = 1'b0; is_load = 1'b0; mem_write = MW_NONE; mem_read = MR_LW;
    #1;
    check_eq({tag, ".after_req"}, 32'(bus_if.bus_req), 32'd0);
    check_eq({tag, ".after_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_valid = 1'b0; is_load = 1'b0; mem_write = MW_NONE; mem_read = MR_LW;
    addr = 32'h0; wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    bus_if_to.bus_ack = 1'b0; bus_if_to.bus_rdata = 32'h0;
    #12;
    check_eq("rst.stall", 32'(stall), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.bus_err", 32'(bus_err), 32'd0);
    check_eq("rst.misal", 32'(misaligned), 32'd0);
    check_eq("rst.req", 32'(bus_if.bus_req), 32'd0);
    check_eq("rst.we", 32'(bus_if.bus_we), 32'd0);
    check_eq("rst.addr", bus_if.bus_addr, 32'h0);
    check_eq("rst.be", 32'(bus_if.bus_be), 32'h0);
    check_eq("rst.wdata", bus_if.bus_wdata, 32'h0);
    check_eq("rst.load", load_data, 32'h0);
    step();
    rst_n = 1'b1;

    //       tag      ld    mw     mr      addr         wdata         rdata    ack we  be
    run_xact("sw",    1'b0, MW_SW, MR_LW,  32'h100, 32'hDEADBEEF, 32'h0,        1, 1, 4'b1111,
             32'h100, 32'hDEADBEEF, 32'h0);
    run_xact("sb",    1'b0, MW_SB, MR_LW,  32'h103, 32'h000000A5, 32'h0,        1, 1, 4'b1000,
             32'h100, 32'hA5A5A5A5, 32'h0);
    run_xact("lb",    1'b1, MW_NONE, MR_LB,  32'h102, 32'h0, 32'h12F45678,     1, 0, 4'b1111,
             32'h100, 32'h0, 32'hFFFFFFF4);
    run_xact("lbu",   1'b1, MW_NONE, MR_LBU, 32'h102, 32'h0, 32'h12F45678,     1, 0, 4'b1111,
             32'h100, 32'h0, 32'h000000F4);
    run_xact("lhu",   1'b1, MW_NONE, MR_LHU, 32'h102, 32'h0, 32'h12F45678,     1, 0, 4'b1111,
             32'h100, 32'h0, 32'h000012F4);
    run_xact("lh",    1'b1, MW_NONE, MR_LH,  32'h100, 32'h0, 32'h00008001,     1, 0, 4'b1111,
             32'h100, 32'h0, 32'hFFFF8001);
    // Ack on the 5th REQ cycle; load_data keeps the previous load result
    run_xact("sh_d5", 1'b0, MW_SH, MR_LW,  32'h102, 32'h1234BEEF, 32'h0,        5, 1, 4'b1100,
             32'h100, 32'hBEEFBEEF, 32'hFFFF8001);
    run_xact("lw_d2", 1'b1, MW_NONE, MR_LW, 32'h104, 32'h0, 32'hCAFEF00D,      2, 0, 4'b1111,
             32'h104, 32'h0, 32'hCAFEF00D);
    run_xact("lw_111", 1'b1, MW_NONE, 3'b111, 32'h108, 32'h0, 32'h55667788,    1, 0, 4'b1111,
             32'h108, 32'h0, 32'h55667788);
    // Store wins over is_load
    run_xact("sb_ld", 1'b1, MW_SB, MR_LB,  32'h101, 32'h0000003C, 32'h99999999, 1, 1, 4'b0010,
             32'h100, 32'h3C3C3C3C, 32'h55667788);

    // bus_ack while idle is ignored
    step();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
    #1;
    check_eq("idle_ack.done", 32'(done), 32'd0);
    check_eq("idle_ack.stall", 32'(stall), 32'd0);
    step();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    #1;
    check_eq("idle_ack.req", 32'(bus_if.bus_req), 32'd0);
    check_eq("idle_ack.load", load_data, 32'h55667788);

`ifdef LSU_MISALIGN_TRAP_EN
    step();
    mem_valid = 1'b1; is_load = 1'b1; mem_read = MR_LW; addr = 32'h102;
    #1;
    check_eq("mis_lw.misal", 32'(misaligned), 32'd1);
    check_eq("mis_lw.done", 32'(done), 32'd1);
    check_eq("mis_lw.stall", 32'(stall), 32'd0);
    step();
    mem_valid = 1'b1; is_load = 1'b0; mem_write = MW_SH; addr = 32'h101;
    #1;
    check_eq("mis_sh.req", 32'(bus_if.bus_req), 32'd0);
    check_eq("mis_sh.misal", 32'(misaligned), 32'd1);
    step();
    mem_valid = 1'b0; mem_write = MW_NONE;
    #1;
    check_eq("mis.after_req", 32'(bus_if.bus_req), 32'd0);
    check_eq("mis.after_misal", 32'(misaligned), 32'd0);
`else
    // Without the trap the word access is truncated to 0x100 and proceeds
    run_xact("lw_102", 1'b1, MW_NONE, MR_LW, 32'h102, 32'h0, 32'h11223344,     1, 0, 4'b1111,
             32'h100, 32'h0, 32'h11223344);
`endif

    // Asynchronous reset in the middle of REQ
    step();
    mem_valid = 1'b1; is_load = 1'b1; mem_read = MR_LW; addr = 32'h300;
    step();
    #1;
    check_eq("arst.pre_req", 32'(bus_if.bus_req), 32'd1);
    #2;
    rst_n = 1'b0; mem_valid = 1'b0; is_load = 1'b0;
    #1;
    check_eq("arst.req", 32'(bus_if.bus_req), 32'd0);
    check_eq("arst.stall", 32'(stall), 32'd0);
    check_eq("arst.addr", bus_if.bus_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    #1;
    check_eq("arst.idle_req", 32'(bus_if.bus_req), 32'd0);
    check_eq("arst.idle_done", 32'(done), 32'd0);

    // Timeout on the TIMEOUT_CYCLES=4 instance; first a good load so the clear is visible
    step();
    mem_valid = 1'b1; is_load = 1'b1; mem_read = MR_LW; addr = 32'h200;
    #1;
    check_eq("to.accept_stall", 32'(stall_to), 32'd1);
    step();
    bus_if_to.bus_ack = 1'b1; bus_if_to.bus_rdata = 32'h87654321;
    #1;
    check_eq("to.ok_req", 32'(bus_if_to.bus_req), 32'd1);
    step();
    bus_if_to.bus_ack = 1'b0; bus_if_to.bus_rdata = 32'h0;
    #1;
    check_eq("to.ok_done", 32'(done_to), 32'd1);
    check_eq("to.ok_load", load_data_to, 32'h87654321);
    check_eq("to.ok_err", 32'(bus_err_to), 32'd0);
    step();
    #1;
    check_eq("to.acc2_stall", 32'(stall_to), 32'd1);
    check_eq("to.acc2_req", 32'(bus_if_to.bus_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check_eq("to.wait_req", 32'(bus_if_to.bus_req), 32'd1);
      check_eq("to.wait_err", 32'(bus_err_to), 32'd0);
    end
    step();
    #1;
    check_eq("to.abort_req", 32'(bus_if_to.bus_req), 32'd0);
    check_eq("to.abort_err", 32'(bus_err_to), 32'd1);
    check_eq("to.abort_done", 32'(done_to), 32'd1);
    check_eq("to.abort_stall", 32'(stall_to), 32'd0);
    check_eq("to.abort_load", load_data_to, 32'h0);
    step();
    mem_valid = 1'b0; is_load = 1'b0;
    #1;
    check_eq("to.after_err", 32'(bus_err_to), 32'd0);
    check_eq("to.after_done", 32'(done_to), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
